// File: rtl/proc_pkg.sv
// Shared definitions for the data-memory responder slice.
// Holds the default datapath sizes, the default read latency and the
// responder state encoding used by data_mem_responder.
package proc_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned READ_LAT = 2;

    // Latency counter only ever holds values up to READ_LAT-1 (max 3).
    localparam int unsigned CNT_W    = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed flop storage for the data-memory responder.
// Ports:
//   clock    - rising-edge clock
//   reset    - asynchronous active-low clear of every word
//   wr_en    - write strobe, wr_data stored at wr_addr on the rising edge
//   wr_addr  - write word address
//   wr_data  - write data
//   rd_addr  - read word address
//   rd_data  - combinational read data for rd_addr
module dmem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts single-word read/write requests with a
// valid/ready handshake. Writes complete at the accept edge with no bubble;
// reads return exactly READ_LAT cycles after the accept edge as a one-cycle
// rdata_valid pulse. The returned word holds between pulses.
// Ports:
//   clock               - rising-edge clock
//   reset               - asynchronous active-low reset
//   req_valid           - request present
//   req_ready           - responder can accept (high only when idle)
//   mem_write_en        - 1 = write, 0 = read (qualified by req_valid)
//   req_addr            - word address
//   mem_data_write_out  - write data
//   memory_data_read_in - read data returned
//   rdata_valid         - one-cycle pulse marking returned data valid
module data_mem_responder #(
    parameter int unsigned DATA_W   = proc_pkg::DATA_W,
    parameter int unsigned ADDR_W   = proc_pkg::ADDR_W,
    parameter int unsigned READ_LAT = proc_pkg::READ_LAT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              mem_write_en,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] mem_data_write_out,
    output logic [DATA_W-1:0] memory_data_read_in,
    output logic              rdata_valid
);

    import proc_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              wr_en;
    logic [DATA_W-1:0] rd_data;

    dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dmem_array (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (req_addr),
        .wr_data (mem_data_write_out),
        .rd_addr (req_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            out_q   <= out_d;
        end
    end

    // The returned word lives in its own register, loaded on the edge that
    // enters RD_RESP, so it holds its value after the pulse even when a new
    // read overwrites the capture register.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cap_d       = cap_q;
        out_d       = out_q;
        req_ready   = 1'b0;
        rdata_valid = 1'b0;
        wr_en       = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (mem_write_en) begin
                        wr_en = 1'b1;
                    end else begin
                        cap_d = rd_data;
                        cnt_d = CNT_LOAD;
                        if (READ_LAT == 1) begin
                            state_d = RD_RESP;
                            out_d   = rd_data;
                        end else begin
                            state_d = RD_WAIT;
                        end
                    end
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = RD_RESP;
                    out_d   = cap_q;
                end
            end
            RD_RESP: begin
                rdata_valid = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign memory_data_read_in = out_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder. Three instances (READ_LAT 2,
// 1 and 4) share one set of request inputs; instance 0 carries the main
// vectors, all three are compared in the latency sequence.
module tb_data_mem_responder;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        mem_write_en;
    logic [4:0]  req_addr;
    logic [31:0] wdata;
    logic [2:0]  rdy;
    logic [2:0]  rv;
    logic [31:0] rd [3];

    int errors = 0;
    int checks = 0;
    int lat_of [3] = '{2, 1, 4};

    typedef struct {
        bit          is_wr;
        logic [4:0]  addr;
        logic [31:0] data;
        string       name;
    } vec_t;

    vec_t vecs [10];

    data_mem_responder #(.DATA_W(32), .ADDR_W(5), .READ_LAT(2)) dut_l2 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy[0]),
        .mem_write_en(mem_write_en), .req_addr(req_addr), .mem_data_write_out(wdata),
        .memory_data_read_in(rd[0]), .rdata_valid(rv[0]));

    data_mem_responder #(.DATA_W(32), .ADDR_W(5), .READ_LAT(1)) dut_l1 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]),
        .mem_write_en(mem_write_en), .req_addr(req_addr), .mem_data_write_out(wdata),
        .memory_data_read_in(rd[1]), .rdata_valid(rv[1]));

    data_mem_responder #(.DATA_W(32), .ADDR_W(5), .READ_LAT(4)) dut_l4 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy[2]),
        .mem_write_en(mem_write_en), .req_addr(req_addr), .mem_data_write_out(wdata),
        .memory_data_read_in(rd[2]), .rdata_valid(rv[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // All tasks start and end at a falling edge; inputs change there.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input string name);
        req_valid    = 1'b1;
        mem_write_en = 1'b1;
        req_addr     = a;
        wdata        = d;
        check({name, " ready"}, {31'd0, rdy[0]}, 32'd1);
        @(posedge clock);
        @(negedge clock);
        req_valid    = 1'b0;
        mem_write_en = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a, input logic [31:0] exp, input string name);
        int lat;
        req_valid    = 1'b1;
        mem_write_en = 1'b0;
        req_addr     = a;
        check({name, " ready"}, {31'd0, rdy[0]}, 32'd1);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            if (rv[0]) begin
                lat = i;
                break;
            end
            @(negedge clock);
        end
        check({name, " latency"}, lat, 32'd2);
        check({name, " data"}, rd[0], exp);
        @(negedge clock);
        check({name, " pulse end"}, {31'd0, rv[0]}, 32'd0);
    endtask

    initial begin
        int lat [3];

        req_valid    = 1'b0;
        mem_write_en = 1'b0;
        req_addr     = '0;
        wdata        = '0;
        reset        = 1'b0;

        vecs[0] = '{1'b0, 5'd7,  32'h0000_0000, "rd7_after_reset"};
        vecs[1] = '{1'b1, 5'd3,  32'hDEAD_BEEF, "wr3"};
        vecs[2] = '{1'b0, 5'd3,  32'hDEAD_BEEF, "raw3"};
        vecs[3] = '{1'b1, 5'd0,  32'h1111_1111, "wr0"};
        vecs[4] = '{1'b1, 5'd31, 32'h3131_3131, "wr31"};
        vecs[5] = '{1'b0, 5'd0,  32'h1111_1111, "rd0"};
        vecs[6] = '{1'b0, 5'd31, 32'h3131_3131, "rd31"};
        vecs[7] = '{1'b1, 5'd7,  32'hAAAA_5555, "wr7"};
        vecs[8] = '{1'b0, 5'd7,  32'hAAAA_5555, "rd7"};
        vecs[9] = '{1'b0, 5'd3,  32'hDEAD_BEEF, "rd3_again"};

        repeat (2) @(negedge clock);
        check("reset rdata_valid", {31'd0, rv[0]}, 32'd0);
        check("reset read data", rd[0], 32'd0);
        reset = 1'b1;

        for (int v = 0; v < 10; v++) begin
            if (vecs[v].is_wr) do_write(vecs[v].addr, vecs[v].data, vecs[v].name);
            else               do_read(vecs[v].addr, vecs[v].data, vecs[v].name);
        end

        // Request held through a pending read: write must wait for IDLE.
        do_write(5'd9, 32'h1234_5678, "wr9");
        req_valid    = 1'b1;
        mem_write_en = 1'b0;
        req_addr     = 5'd9;
        @(posedge clock);
        @(negedge clock);
        mem_write_en = 1'b1;
        wdata        = 32'hFFFF_FFFF;
        check("busy ready low", {31'd0, rdy[0]}, 32'd0);
        lat[0] = 0;
        for (int i = 1; i <= 8; i++) begin
            if (rv[0]) begin
                lat[0] = i;
                break;
            end
            @(negedge clock);
        end
        check("held latency", lat[0], 32'd2);
        check("held old data", rd[0], 32'h1234_5678);
        @(negedge clock);
        check("held pulse end", {31'd0, rv[0]}, 32'd0);
        check("held data holds", rd[0], 32'h1234_5678);
        check("held ready back", {31'd0, rdy[0]}, 32'd1);
        @(posedge clock);
        @(negedge clock);
        req_valid    = 1'b0;
        mem_write_en = 1'b0;
        do_read(5'd9, 32'hFFFF_FFFF, "rd9_after_held_wr");

        // Reset during RD_WAIT aborts the read and clears memory.
        do_write(5'd5, 32'h55AA_55AA, "wr5");
        req_valid    = 1'b1;
        mem_write_en = 1'b0;
        req_addr     = 5'd5;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        reset     = 1'b0;
        @(negedge clock);
        check("mid-read reset data", rd[0], 32'd0);
        reset  = 1'b1;
        lat[0] = 0;
        for (int i = 1; i <= 6; i++) begin
            if (rv[0]) lat[0] = i;
            @(negedge clock);
        end
        check("aborted read no pulse", lat[0], 32'd0);
        check("aborted read data", rd[0], 32'd0);
        for (int a = 0; a < 32; a++) begin
            do_read(5'(a), 32'd0, $sformatf("clear_rd%0d", a));
        end

        // Latency of all three builds on one shared read.
        repeat (4) @(negedge clock);
        do_write(5'd4, 32'hCAFE_F00D, "wr4");
        req_valid    = 1'b1;
        mem_write_en = 1'b0;
        req_addr     = 5'd4;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        lat = '{0, 0, 0};
        for (int i = 1; i <= 8; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (rv[j] && lat[j] == 0) lat[j] = i;
            end
            @(negedge clock);
        end
        for (int j = 0; j < 3; j++) begin
            check($sformatf("lat build %0d", lat_of[j]), lat[j], lat_of[j]);
            check($sformatf("data build %0d", lat_of[j]), rd[j], 32'hCAFE_F00D);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width.
REQ-002 SHALL have parameter ADDR_W, default 5, word address width (depth = 2**ADDR_W words).
REQ-003 SHALL have parameter READ_LAT, default 2, cycles from read accept edge to rdata_valid edge; legal range 1..4.
REQ-004 SHALL have port clock  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  in  1  requester presents a request.
REQ-007 SHALL have port req_ready  out  1  responder can accept a request this cycle.
REQ-008 SHALL have port mem_write_en  in  1  1 = write request, 0 = read request; qualified by req_valid.
REQ-009 SHALL have port req_addr  in  ADDR_W  word address.
REQ-010 SHALL have port mem_data_write_out  in  DATA_W  write data from the execute stage.
REQ-011 SHALL have port memory_data_read_in  out  DATA_W  read data returned to the execute stage.
REQ-012 SHALL have port rdata_valid  out  1  one-cycle pulse marking memory_data_read_in valid.

Function
REQ-013 SHALL accept a request on a rising edge where req_valid && req_ready.
REQ-014 SHALL implement FSM IDLE, RD_WAIT, RD_RESP; req_ready = 1 only in IDLE.
REQ-015 Write accept in IDLE: SHALL update mem[req_addr] with mem_data_write_out at the accept edge and remain in IDLE (back-to-back writes, no bubble).
REQ-016 Read accept in IDLE: SHALL capture mem[req_addr] at the accept edge into a read-data register, load a latency counter with READ_LAT-1, and go to RD_WAIT (READ_LAT>1) or RD_RESP (READ_LAT=1).
REQ-017 RD_WAIT: SHALL decrement the counter each edge and go to RD_RESP when the counter reaches 1.
REQ-018 RD_RESP: SHALL drive rdata_valid = 1 and memory_data_read_in = captured data for exactly one cycle, then return to IDLE.
REQ-019 Read latency SHALL be exactly READ_LAT cycles: rdata_valid is high in cycle k+READ_LAT for an accept at edge k.
REQ-020 memory_data_read_in SHALL hold its last returned value when rdata_valid = 0.
REQ-021 Requests presented while req_ready = 0 SHALL be ignored and SHALL NOT alter memory or state.
REQ-022 Read-after-write: a read accepted one cycle after a write to the same address SHALL return the newly written data.
REQ-023 Write data during a pending read cannot occur (req_ready = 0); the captured read data SHALL therefore be immune to later writes.
REQ-024 Address wrap: all 2**ADDR_W addresses are valid; no out-of-range condition exists.

Reset
REQ-025 On reset low SHALL asynchronously force state IDLE, req_ready 1 (after release), rdata_valid 0, memory_data_read_in 0, counter 0, all memory words 0.
REQ-026 Reset asserted mid-read SHALL abort the read with no rdata_valid pulse after release.
REQ-027 First request SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-028 Shared package proc_pkg SHALL hold DATA_W (32), ADDR_W (5), READ_LAT default, and the state enum (IDLE, RD_WAIT, RD_RESP).
REQ-029 Storage SHALL be one sub-module dmem_array (flop array, sync write, combinational read, async active-low clear); the FSM and counter stay in data_mem_responder.

Verification
REQ-030 Reset then read addr 7 -> rdata_valid pulse 2 cycles after accept, memory_data_read_in = 0x0000_0000.
REQ-031 Write 0xDEAD_BEEF to addr 3, next cycle read addr 3 -> req_ready high across the write, returns 0xDEAD_BEEF after 2 cycles.
REQ-032 Writes to addr 0 and addr 31 on consecutive cycles, then read both -> 0x1111_1111 and 0x3131_3131 respectively, no bubble between the writes.
REQ-033 Read accepted, req_valid held with write 0xFFFF_FFFF to same addr during RD_WAIT -> write ignored, read returns the old value, write accepted only after return to IDLE.
REQ-034 Reset asserted in RD_WAIT -> no rdata_valid after release, memory_data_read_in = 0, all words read back 0.
REQ-035 READ_LAT = 1 and READ_LAT = 4 builds -> rdata_valid exactly 1 and 4 cycles after accept.
